// File: rtl/spi_cfg_pkg.sv
// Shared widths, register map and controller state encoding for the SPI
// configuration master.
package spi_cfg_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_MAX       = 7'h04;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_cfg_master.sv
// Buffers register-write requests and serialises each as a 16-bit SPI mode-0
// write frame (1, addr[6:0], data[7:0]) on registered nCS/SCLK/COPI outputs.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_IDLE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              nCS,
  output logic              SCLK,
  output logic              COPI,
  output logic              busy,
  output logic              err,
  output logic [7:0]        frames_sent
);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 phase_q, phase_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [7:0]           frames_q, frames_d;
  logic                 err_q, ncs_q, sclk_q, copi_q;
  logic                 ncs_d, sclk_d, copi_d;

  logic                 accept, legal, pop, fifo_full, fifo_empty;
  logic [FRAME_W-2:0]   fifo_rdata;

  assign accept = in_valid & in_ready;
  assign legal  = (in_addr <= ADDR_MAX);

  sync_fifo #(
    .WIDTH (FRAME_W - 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept & legal),
    .wdata ({in_addr, in_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 8'd1;
    bit_d    = bit_q;
    phase_d  = phase_q;
    shreg_d  = shreg_q;
    frames_d = frames_q;
    pop      = 1'b0;
    ncs_d    = 1'b1;
    sclk_d   = 1'b0;
    copi_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = {1'b1, fifo_rdata};
          state_d = StSetup;
        end
      end
      StSetup: begin
        ncs_d  = 1'b0;
        copi_d = shreg_q[FRAME_W-1];
        if (cnt_q == 8'(CS_SETUP - 1)) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end
      end
      StShift: begin
        ncs_d  = 1'b0;
        sclk_d = phase_q;
        copi_d = shreg_q[FRAME_W-1];
        if (cnt_q == 8'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Shift at the end of the high phase so COPI moves with SCLK falling.
            phase_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = StHold;
            end else begin
              bit_d   = bit_q + 4'd1;
              shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      StHold: begin
        ncs_d  = 1'b0;
        copi_d = shreg_q[FRAME_W-1];
        if (cnt_q == 8'(CS_HOLD - 1)) begin
          state_d  = StGap;
          cnt_d    = '0;
          frames_d = frames_q + 8'd1;
        end
      end
      StGap: begin
        // The IDLE pop cycle also keeps nCS high, so GAP covers CS_IDLE-1 cycles.
        if (cnt_q >= 8'(CS_IDLE - 2)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      shreg_q  <= '0;
      frames_q <= '0;
      err_q    <= 1'b0;
      ncs_q    <= 1'b1;
      sclk_q   <= 1'b0;
      copi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      shreg_q  <= shreg_d;
      frames_q <= frames_d;
      err_q    <= accept & ~legal;
      ncs_q    <= ncs_d;
      sclk_q   <= sclk_d;
      copi_q   <= copi_d;
    end
  end

  assign in_ready    = ~fifo_full;
  assign busy        = (state_q != StIdle) | ~fifo_empty;
  assign err         = err_q;
  assign frames_sent = frames_q;
  assign nCS         = ncs_q;
  assign SCLK        = sclk_q;
  assign COPI        = copi_q;

endmodule
